// File: rtl/tub_scan_driver_if.sv
// ---------------------------------------------------------------------------
// tub_scan_driver_if : display bus between the MMIO register, scan driver
//                      and segment encoder.            Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface tub_scan_driver_if;
  logic        en;
  logic [31:0] value_i;
  logic        neg_i;
  logic        blank_i;
  logic [4:0]  digit_code;
  logic [7:0]  digit_sel;
  logic        frame_pulse;
  logic        sign_ovf;

  modport master (
    output en, value_i, neg_i, blank_i,
    input  digit_code, digit_sel, frame_pulse, sign_ovf
  );

  modport slave (
    input  en, value_i, neg_i, blank_i,
    output digit_code, digit_sel, frame_pulse, sign_ovf
  );
endinterface

`default_nettype wire

// File: rtl/tub_scan_driver.sv
// ---------------------------------------------------------------------------
// tub_scan_driver : 8-digit time-multiplexed seven-segment scan driver with
//                   per-frame shadow latch, leading-zero blanking and sign.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tub_scan_driver #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  tub_scan_driver_if.slave   bus
);

  localparam int unsigned       CNT_W   = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      shadow_val_q, shadow_val_d;
  logic             shadow_neg_q, shadow_neg_d;
  logic             shadow_blank_q, shadow_blank_d;
  logic             loaded_q, loaded_d;
  logic [4:0]       code_q, code_d;
  logic [7:0]       sel_q, sel_d;
  logic             pulse_q, pulse_d;
  logic             ovf_q, ovf_d;

  logic             slot_end;
  logic             frame_end;
  logic [2:0]       msd;
  logic             blank_eff;
  logic             sign_show;
  logic [3:0]       sp;
  logic [3:0]       nib;
  logic [7:0]       sel_onehot;

  always_comb begin
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    shadow_val_d   = shadow_val_q;
    shadow_neg_d   = shadow_neg_q;
    shadow_blank_d = shadow_blank_q;
    loaded_d       = loaded_q;
    ovf_d          = ovf_q;
    code_d         = 5'h00;
    sel_d          = 8'h00;
    msd            = 3'd0;

    slot_end  = bus.en && (cnt_q == CNT_MAX);
    frame_end = slot_end && (idx_q == 3'd7);
    pulse_d   = frame_end;

    if (bus.en) begin
      cnt_d = slot_end ? '0 : cnt_q + 1'b1;
      idx_d = slot_end ? idx_q + 3'd1 : idx_q;
    end

    if (frame_end) begin
      shadow_val_d   = bus.value_i;
      shadow_neg_d   = bus.neg_i;
      shadow_blank_d = bus.blank_i;
      loaded_d       = 1'b1;
      ovf_d          = bus.neg_i && (bus.value_i[31:28] != 4'h0);
    end

    for (int k = 1; k < 8; k++) begin
      if (shadow_val_q[4*k +: 4] != 4'h0) msd = 3'(k);
    end

    // Before the first frame latch the display shows a lone "0", so blank.
    blank_eff  = shadow_blank_q || !loaded_q;
    sign_show  = shadow_neg_q && (shadow_val_q[31:28] == 4'h0);
    sp         = blank_eff ? ({1'b0, msd} + 4'd1) : 4'd7;
    nib        = shadow_val_q[{idx_q, 2'b00} +: 4];
    sel_onehot = 8'd1 << idx_q;

    if (!bus.en) begin
      code_d = 5'h00;
      sel_d  = 8'h00;
    end else if (sign_show && ({1'b0, idx_q} == sp)) begin
      code_d = 5'h10;
      sel_d  = sel_onehot;
    end else if (blank_eff && (idx_q > msd)) begin
      code_d = 5'h00;
      sel_d  = 8'h00;
    end else begin
      code_d = {1'b0, nib};
      sel_d  = sel_onehot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      idx_q          <= 3'd0;
      shadow_val_q   <= 32'h0;
      shadow_neg_q   <= 1'b0;
      shadow_blank_q <= 1'b0;
      loaded_q       <= 1'b0;
      code_q         <= 5'h00;
      sel_q          <= 8'h00;
      pulse_q        <= 1'b0;
      ovf_q          <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      shadow_val_q   <= shadow_val_d;
      shadow_neg_q   <= shadow_neg_d;
      shadow_blank_q <= shadow_blank_d;
      loaded_q       <= loaded_d;
      code_q         <= code_d;
      sel_q          <= sel_d;
      pulse_q        <= pulse_d;
      ovf_q          <= ovf_d;
    end
  end

  assign bus.digit_code  = code_q;
  assign bus.digit_sel   = sel_q;
  assign bus.frame_pulse = pulse_q;
  assign bus.sign_ovf    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_tub_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_tub_scan_driver : directed bench for tub_scan_driver at SCAN_DIV=4.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tub_scan_driver;

  localparam int SCAN_DIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  tub_scan_driver_if bus();

  tub_scan_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [4:0] cap_code [8];
  logic [7:0] cap_sel  [8];
  logic       cap_ovf;
  logic [4:0] exp_code [8];
  logic [7:0] exp_sel  [8];

  // Samples the middle of each of the 8 slots; caller positions the first sample.
  task automatic capture_frame(input int chg_slot, input logic [31:0] chg_val);
    for (int k = 0; k < 8; k++) begin
      cap_code[k] = bus.digit_code;
      cap_sel[k]  = bus.digit_sel;
      if (k == 0) cap_ovf = bus.sign_ovf;
      if (k == chg_slot) bus.value_i = chg_val;
      if (k < 7) repeat (4) @(negedge clk);
    end
  endtask

  task automatic wait_pulse();
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.frame_pulse === 1'b1) seen = 1'b1;
    end
    total_cnt++;
    if (!seen) $display("FAIL wait_pulse got no frame_pulse exp pulse within 100 cycles");
    else pass_cnt++;
  endtask

  task automatic test_reset();
    bus.en = 1'b0; bus.value_i = 32'h0; bus.neg_i = 1'b0; bus.blank_i = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt += 4;
    if (bus.digit_code !== 5'h00) $display("FAIL rst_code got %h exp 00", bus.digit_code); else pass_cnt++;
    if (bus.digit_sel !== 8'h00) $display("FAIL rst_sel got %h exp 00", bus.digit_sel); else pass_cnt++;
    if (bus.frame_pulse !== 1'b0) $display("FAIL rst_pulse got %b exp 0", bus.frame_pulse); else pass_cnt++;
    if (bus.sign_ovf !== 1'b0) $display("FAIL rst_ovf got %b exp 0", bus.sign_ovf); else pass_cnt++;

    rst_n = 1'b1; bus.en = 1'b1;
    bus.value_i = 32'h0000_00A5; bus.neg_i = 1'b0; bus.blank_i = 1'b1;
    repeat (2) @(negedge clk);
    capture_frame(-1, 32'h0);
    for (int k = 0; k < 8; k++) begin
      total_cnt += 2;
      if (cap_code[k] !== 5'h00) $display("FAIL first_code slot%0d got %h exp 00", k, cap_code[k]); else pass_cnt++;
      if (cap_sel[k] !== ((k == 0) ? 8'h01 : 8'h00))
        $display("FAIL first_sel slot%0d got %h exp %h", k, cap_sel[k], (k == 0) ? 8'h01 : 8'h00);
      else pass_cnt++;
    end
  endtask

  task automatic test_blank_hex();
    wait_pulse();
    @(negedge clk);
    total_cnt++;
    if (bus.frame_pulse !== 1'b0) $display("FAIL pulse_width got %b exp 0", bus.frame_pulse); else pass_cnt++;
    @(negedge clk);
    capture_frame(-1, 32'h0);
    for (int k = 0; k < 8; k++) begin
      exp_code[k] = (k == 0) ? 5'h05 : (k == 1) ? 5'h0A : 5'h00;
      exp_sel[k]  = (k < 2) ? 8'(1 << k) : 8'h00;
      total_cnt += 2;
      if (cap_code[k] !== exp_code[k]) $display("FAIL a5_code slot%0d got %h exp %h", k, cap_code[k], exp_code[k]); else pass_cnt++;
      if (cap_sel[k] !== exp_sel[k]) $display("FAIL a5_sel slot%0d got %h exp %h", k, cap_sel[k], exp_sel[k]); else pass_cnt++;
    end
  endtask

  task automatic test_sign_blank();
    bus.value_i = 32'h0000_0123; bus.neg_i = 1'b1; bus.blank_i = 1'b1;
    wait_pulse();
    repeat (2) @(negedge clk);
    capture_frame(-1, 32'h0);
    for (int k = 0; k < 8; k++) begin
      exp_code[k] = (k == 0) ? 5'h03 : (k == 1) ? 5'h02 : (k == 2) ? 5'h01 : (k == 3) ? 5'h10 : 5'h00;
      exp_sel[k]  = (k < 4) ? 8'(1 << k) : 8'h00;
      total_cnt += 2;
      if (cap_code[k] !== exp_code[k]) $display("FAIL sgn_code slot%0d got %h exp %h", k, cap_code[k], exp_code[k]); else pass_cnt++;
      if (cap_sel[k] !== exp_sel[k]) $display("FAIL sgn_sel slot%0d got %h exp %h", k, cap_sel[k], exp_sel[k]); else pass_cnt++;
    end
    total_cnt++;
    if (cap_ovf !== 1'b0) $display("FAIL sgn_ovf got %b exp 0", cap_ovf); else pass_cnt++;
  endtask

  task automatic test_sign_ovf();
    bus.value_i = 32'h8000_0001; bus.neg_i = 1'b1; bus.blank_i = 1'b0;
    wait_pulse();
    repeat (2) @(negedge clk);
    capture_frame(-1, 32'h0);
    for (int k = 0; k < 8; k++) begin
      exp_code[k] = (k == 0) ? 5'h01 : (k == 7) ? 5'h08 : 5'h00;
      exp_sel[k]  = 8'(1 << k);
      total_cnt += 2;
      if (cap_code[k] !== exp_code[k]) $display("FAIL ovf_code slot%0d got %h exp %h", k, cap_code[k], exp_code[k]); else pass_cnt++;
      if (cap_sel[k] !== exp_sel[k]) $display("FAIL ovf_sel slot%0d got %h exp %h", k, cap_sel[k], exp_sel[k]); else pass_cnt++;
    end
    total_cnt++;
    if (cap_ovf !== 1'b1) $display("FAIL ovf_flag got %b exp 1", cap_ovf); else pass_cnt++;
  endtask

  task automatic test_zero_neg();
    bus.value_i = 32'h0; bus.neg_i = 1'b1; bus.blank_i = 1'b0;
    wait_pulse();
    repeat (2) @(negedge clk);
    capture_frame(-1, 32'h0);
    for (int k = 0; k < 8; k++) begin
      exp_code[k] = (k == 7) ? 5'h10 : 5'h00;
      exp_sel[k]  = 8'(1 << k);
      total_cnt += 2;
      if (cap_code[k] !== exp_code[k]) $display("FAIL zneg_code slot%0d got %h exp %h", k, cap_code[k], exp_code[k]); else pass_cnt++;
      if (cap_sel[k] !== exp_sel[k]) $display("FAIL zneg_sel slot%0d got %h exp %h", k, cap_sel[k], exp_sel[k]); else pass_cnt++;
    end
    total_cnt++;
    if (cap_ovf !== 1'b0) $display("FAIL zneg_ovf got %b exp 0", cap_ovf); else pass_cnt++;
  endtask

  task automatic test_no_tearing();
    int n;
    bus.value_i = 32'h0000_00A5; bus.neg_i = 1'b0; bus.blank_i = 1'b0;
    wait_pulse();
    repeat (2) @(negedge clk);
    capture_frame(3, 32'h1111_1111);
    for (int k = 0; k < 8; k++) begin
      exp_code[k] = (k == 0) ? 5'h05 : (k == 1) ? 5'h0A : 5'h00;
      total_cnt++;
      if (cap_code[k] !== exp_code[k]) $display("FAIL tear_code slot%0d got %h exp %h", k, cap_code[k], exp_code[k]); else pass_cnt++;
    end
    // Last capture sample sits 30 cycles after the pulse.
    n = 30;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (bus.frame_pulse === 1'b1) break;
    end
    total_cnt++;
    if (n !== 32) $display("FAIL pulse_spacing got %0d exp 32", n); else pass_cnt++;
    repeat (2) @(negedge clk);
    capture_frame(-1, 32'h0);
    for (int k = 0; k < 8; k++) begin
      total_cnt++;
      if (cap_code[k] !== 5'h01) $display("FAIL new_code slot%0d got %h exp 01", k, cap_code[k]); else pass_cnt++;
    end
  endtask

  task automatic test_enable();
    wait_pulse();
    repeat (22) @(negedge clk);
    total_cnt++;
    if (bus.digit_sel !== 8'h20) $display("FAIL en_pre_sel got %h exp 20", bus.digit_sel); else pass_cnt++;
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total_cnt += 2;
      if (bus.digit_sel !== 8'h00) $display("FAIL en_off_sel cyc%0d got %h exp 00", i, bus.digit_sel); else pass_cnt++;
      if (bus.frame_pulse !== 1'b0) $display("FAIL en_off_pulse cyc%0d got %b exp 0", i, bus.frame_pulse); else pass_cnt++;
    end
    bus.en = 1'b1;
    @(negedge clk);
    total_cnt += 2;
    if (bus.digit_sel !== 8'h20) $display("FAIL en_resume_sel got %h exp 20", bus.digit_sel); else pass_cnt++;
    if (bus.digit_code !== 5'h01) $display("FAIL en_resume_code got %h exp 01", bus.digit_code); else pass_cnt++;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (bus.digit_sel !== 8'h40) $display("FAIL en_next_sel got %h exp 40", bus.digit_sel); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    wait_pulse();
    repeat (10) @(negedge clk);
    total_cnt++;
    if (bus.digit_sel !== 8'h04) $display("FAIL arst_pre_sel got %h exp 04", bus.digit_sel); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt += 3;
    if (bus.digit_sel !== 8'h00) $display("FAIL arst_sel got %h exp 00", bus.digit_sel); else pass_cnt++;
    if (bus.digit_code !== 5'h00) $display("FAIL arst_code got %h exp 00", bus.digit_code); else pass_cnt++;
    if (bus.frame_pulse !== 1'b0) $display("FAIL arst_pulse got %b exp 0", bus.frame_pulse); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    capture_frame(-1, 32'h0);
    for (int k = 0; k < 8; k++) begin
      total_cnt += 2;
      if (cap_code[k] !== 5'h00) $display("FAIL arst_frame_code slot%0d got %h exp 00", k, cap_code[k]); else pass_cnt++;
      if (cap_sel[k] !== ((k == 0) ? 8'h01 : 8'h00))
        $display("FAIL arst_frame_sel slot%0d got %h exp %h", k, cap_sel[k], (k == 0) ? 8'h01 : 8'h00);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_blank_hex();
    test_sign_blank();
    test_sign_ovf();
    test_zero_neg();
    test_no_tearing();
    test_enable();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
